// File: rtl/cflog_pkg.sv
// rtl/cflog_pkg.sv - shared encodings and sizing defaults for the CF-Log controller and memory
package cflog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOG    = 2'd1,
        ST_REPORT = 2'd2,
        ST_CLEAR  = 2'd3
    } cflog_state_e;

    localparam logic [1:0] WEN_BOTH = 2'b11;
    localparam logic [1:0] WEN_NONE = 2'b00;

    localparam int CFLOG_LOG_WORDS = 512;
    localparam int CFLOG_ADDR_MSB  = 9;

endpackage

// File: rtl/cflog_ctrl.sv
// rtl/cflog_ctrl.sv - CF-Log sequencing controller: logs src/dst pairs, reports, then zero-clears
module cflog_ctrl
    import cflog_pkg::*;
#(
    parameter int LOG_WORDS = CFLOG_LOG_WORDS,
    parameter int ADDR_MSB  = CFLOG_ADDR_MSB
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                entry_valid,
    input  logic [15:0]         entry_src,
    input  logic [15:0]         entry_dst,
    output logic                entry_ready,
    input  logic                sw_flush_req,
    input  logic                sw_ack,
    input  logic                sw_rd_en,
    output logic [1:0]          ram_wen,
    output logic [ADDR_MSB:0]   write_addr,
    output logic [15:0]         ram_din1,
    output logic [15:0]         ram_din2,
    output logic                ram_cen,
    output logic [ADDR_MSB:0]   log_ptr,
    output logic                irq_report,
    output logic [1:0]          ctrl_state
);

    localparam int AW = ADDR_MSB + 1;
    localparam logic [AW-1:0] LAST_PAIR = AW'(LOG_WORDS - 2);
    localparam logic [AW-1:0] FULL_PTR  = AW'(LOG_WORDS);
    localparam logic [AW-1:0] PAIR      = AW'(2);

    cflog_state_e  state;
    logic [AW-1:0] clr_ptr;
    logic          accept;
    logic          clr_done;
    logic          go_report;

    // Handshake-driven outputs are gated by reset so a reset cycle never writes memory.
    assign entry_ready = !reset && (state == ST_LOG) && (log_ptr <= LAST_PAIR);
    assign accept      = entry_valid && entry_ready;
    assign clr_done    = (clr_ptr + PAIR) >= log_ptr;
    assign go_report   = (accept && ((log_ptr + PAIR) == FULL_PTR))
                       || (sw_flush_req && (accept || (log_ptr != '0)));
    assign ram_cen     = !(!reset && (state == ST_REPORT) && sw_rd_en);
    assign ctrl_state  = state;

    // Single shared write port: log writes and clear writes are mutually exclusive by state.
    always_comb begin
        ram_wen    = WEN_NONE;
        write_addr = '0;
        ram_din1   = '0;
        ram_din2   = '0;
        if (accept) begin
            ram_wen    = WEN_BOTH;
            write_addr = log_ptr;
            ram_din1   = entry_src;
            ram_din2   = entry_dst;
        end else if (!reset && (state == ST_CLEAR)) begin
            ram_wen    = WEN_BOTH;
            write_addr = clr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            log_ptr    <= '0;
            clr_ptr    <= '0;
            irq_report <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_LOG;
                    end
                end
                ST_LOG: begin
                    if (accept) begin
                        log_ptr <= log_ptr + PAIR;
                    end
                    if (go_report) begin
                        state      <= ST_REPORT;
                        irq_report <= 1'b1;
                    end else if (!enable && !accept) begin
                        state <= ST_IDLE;
                    end
                end
                ST_REPORT: begin
                    if (sw_ack) begin
                        state      <= ST_CLEAR;
                        clr_ptr    <= '0;
                        irq_report <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_done) begin
                        log_ptr <= '0;
                        clr_ptr <= '0;
                        state   <= enable ? ST_LOG : ST_IDLE;
                    end else begin
                        clr_ptr <= clr_ptr + PAIR;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cflog_ctrl.sv
// tb/tb_cflog_ctrl.sv - scoreboard bench for cflog_ctrl with a behavioural log/memory model
module tb_cflog_ctrl;

    localparam int LOG_WORDS = 512;
    localparam int ADDR_MSB  = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              entry_valid;
    logic [15:0]       entry_src;
    logic [15:0]       entry_dst;
    logic              entry_ready;
    logic              sw_flush_req;
    logic              sw_ack;
    logic              sw_rd_en;
    logic [1:0]        ram_wen;
    logic [ADDR_MSB:0] write_addr;
    logic [15:0]       ram_din1;
    logic [15:0]       ram_din2;
    logic              ram_cen;
    logic [ADDR_MSB:0] log_ptr;
    logic              irq_report;
    logic [1:0]        ctrl_state;

    cflog_ctrl #(.LOG_WORDS(LOG_WORDS), .ADDR_MSB(ADDR_MSB)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .entry_valid(entry_valid), .entry_src(entry_src), .entry_dst(entry_dst),
        .entry_ready(entry_ready), .sw_flush_req(sw_flush_req), .sw_ack(sw_ack),
        .sw_rd_en(sw_rd_en), .ram_wen(ram_wen), .write_addr(write_addr),
        .ram_din1(ram_din1), .ram_din2(ram_din2), .ram_cen(ram_cen),
        .log_ptr(log_ptr), .irq_report(irq_report), .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [41:0]       exp_q[$];
    logic [31:0]       ents[$];
    logic [ADDR_MSB:0] m_ptr;
    logic [15:0]       mem[0:LOG_WORDS-1];

    initial begin
        for (int i = 0; i < LOG_WORDS; i++) mem[i] = 16'h0;
    end

    always @(posedge clk) begin
        if (ram_wen == 2'b11 && int'(write_addr) < LOG_WORDS - 1) begin
            mem[write_addr]         <= ram_din1;
            mem[write_addr + 10'd1] <= ram_din2;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_wen !== 2'b00) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: wen %b addr %0d din %h/%h, expected no write",
                         ram_wen, write_addr, ram_din1, ram_din2);
            end else begin
                logic [41:0] e;
                e = exp_q.pop_front();
                check("write_port", 64'({ram_wen, write_addr, ram_din1, ram_din2}), 64'({2'b11, e}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_entry(input logic [15:0] s, input logic [15:0] d, input bit flush);
        int w = 0;
        entry_valid = 1'b1;
        entry_src   = s;
        entry_dst   = d;
        #1;
        while (!entry_ready && w < 20) begin
            tick();
            w++;
        end
        if (!entry_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL entry_timeout: entry_ready stayed 0, expected 1 within 20 cycles");
            entry_valid = 1'b0;
            return;
        end
        sw_flush_req = flush;
        exp_q.push_back({m_ptr, s, d});
        ents.push_back({s, d});
        m_ptr = m_ptr + 10'd2;
        tick();
        entry_valid  = 1'b0;
        sw_flush_req = 1'b0;
    endtask

    task automatic check_mem_log();
        int bad = 0;
        for (int i = 0; i < ents.size(); i++) begin
            if (mem[2*i] !== ents[i][31:16] || mem[2*i+1] !== ents[i][15:0]) bad++;
        end
        check("mem_contents_bad_pairs", 64'(bad), 64'(0));
    endtask

    task automatic do_clear(input bit en_after);
        int n = 0;
        int bad = 0;
        logic [ADDR_MSB:0] used;
        used = m_ptr;
        for (int a = 0; a < int'(used); a += 2) exp_q.push_back({10'(a), 16'h0, 16'h0});
        enable = en_after;
        sw_ack = 1'b1;
        tick();
        sw_ack = 1'b0;
        while (ctrl_state == 2'd3 && n < 1000) begin
            n++;
            tick();
        end
        check("clear_cycles", 64'(n), 64'(used >> 1));
        check("ptr_after_clear", 64'(log_ptr), 64'(0));
        check("state_after_clear", 64'(ctrl_state), en_after ? 64'(1) : 64'(0));
        check("irq_after_clear", 64'(irq_report), 64'(0));
        for (int a = 0; a < int'(used); a++) if (mem[a] !== 16'h0) bad++;
        check("mem_zeroed_bad_words", 64'(bad), 64'(0));
        m_ptr = '0;
        ents.delete();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; entry_valid = 1'b0; entry_src = '0; entry_dst = '0;
        sw_flush_req = 1'b0; sw_ack = 1'b0; sw_rd_en = 1'b0; m_ptr = '0;
        tick();
        enable = 1'b1; entry_valid = 1'b1; #1;
        check("rst_state", 64'(ctrl_state), 64'(0));
        check("rst_ready", 64'(entry_ready), 64'(0));
        check("rst_outputs", 64'({ram_wen, write_addr, ram_din1, ram_din2, irq_report, ram_cen, log_ptr}),
              64'({2'b00, 10'd0, 16'h0, 16'h0, 1'b0, 1'b1, 10'd0}));
        entry_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("idle_to_log", 64'(ctrl_state), 64'(1));

        // First entry with same-cycle write port checks
        entry_valid = 1'b1; entry_src = 16'hE0A2; entry_dst = 16'hE100; #1;
        exp_q.push_back({10'd0, 16'hE0A2, 16'hE100});
        ents.push_back({16'hE0A2, 16'hE100});
        m_ptr = 10'd2;
        check("first_same_cycle", 64'({ram_wen, write_addr, ram_din1, ram_din2}),
              64'({2'b11, 10'd0, 16'hE0A2, 16'hE100}));
        tick();
        entry_valid = 1'b0;
        check("first_ptr", 64'(log_ptr), 64'(2));
        check("first_mem", 64'({mem[0], mem[1]}), 64'({16'hE0A2, 16'hE100}));

        // Fill to capacity back to back
        for (int i = 1; i < LOG_WORDS / 2; i++) send_entry(16'($urandom), 16'($urandom), 1'b0);
        check("full_ptr", 64'(log_ptr), 64'(LOG_WORDS));
        check("full_irq", 64'(irq_report), 64'(1));
        check("full_state", 64'(ctrl_state), 64'(2));
        entry_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("full_stall_ready", 64'(entry_ready), 64'(0));
            tick();
        end
        entry_valid = 1'b0;
        check_mem_log();
        sw_rd_en = 1'b1; #1;
        check("report_cen_rd", 64'(ram_cen), 64'(0));
        sw_rd_en = 1'b0; #1;
        check("report_cen_idle", 64'(ram_cen), 64'(1));
        do_clear(1'b1);

        // Flush coinciding with the fourth accept
        for (int i = 0; i < 3; i++) send_entry(16'($urandom), 16'($urandom), 1'b0);
        send_entry(16'h1234, 16'h5678, 1'b1);
        check("flush_accept_ptr", 64'(log_ptr), 64'(8));
        check("flush_accept_state", 64'(ctrl_state), 64'(2));
        check("flush_accept_mem6", 64'({mem[6], mem[7]}), 64'({16'h1234, 16'h5678}));
        check_mem_log();
        sw_rd_en = 1'b1; #1;
        check("report_cen_rd2", 64'(ram_cen), 64'(0));
        sw_rd_en = 1'b0;
        do_clear(1'b1);
        check("ready_after_clear", 64'(entry_ready), 64'(1));

        // Flush at empty log and stray ack are both ignored
        sw_flush_req = 1'b1; sw_ack = 1'b1;
        tick();
        sw_flush_req = 1'b0; sw_ack = 1'b0;
        check("empty_flush_state", 64'(ctrl_state), 64'(1));
        check("empty_flush_irq", 64'(irq_report), 64'(0));

        // Randomised rounds
        for (int r = 0; r < 4; r++) begin
            int n;
            bit fl;
            bit en_after;
            n = $urandom_range(1, 12);
            fl = 1'($urandom_range(0, 1));
            en_after = 1'($urandom_range(0, 1));
            for (int i = 0; i < n - 1; i++) send_entry(16'($urandom), 16'($urandom), 1'b0);
            send_entry(16'($urandom), 16'($urandom), fl);
            if (!fl) begin
                sw_flush_req = 1'b1;
                tick();
                sw_flush_req = 1'b0;
            end
            check("rnd_report_state", 64'(ctrl_state), 64'(2));
            check("rnd_ptr", 64'(log_ptr), 64'(m_ptr));
            check_mem_log();
            do_clear(en_after);
            enable = 1'b1;
        end

        // Reset in the middle of a clear
        for (int i = 0; i < 4; i++) send_entry(16'($urandom), 16'($urandom), 1'b0);
        sw_flush_req = 1'b1;
        tick();
        sw_flush_req = 1'b0;
        check("pre_reset_report", 64'(ctrl_state), 64'(2));
        exp_q.push_back({10'd0, 16'h0, 16'h0});
        exp_q.push_back({10'd2, 16'h0, 16'h0});
        sw_ack = 1'b1;
        tick();
        sw_ack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        check("midclear_reset", 64'({ctrl_state, log_ptr, ram_wen, irq_report, ram_cen}),
              64'({2'd0, 10'd0, 2'b00, 1'b0, 1'b1}));
        m_ptr = '0;
        ents.delete();
        tick();
        tick();
        check("scoreboard_drain", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cflog_ctrl.md
Name: cflog_ctrl

Overview:
- Sequencing controller for the CF-Log memory. Accepts control-flow log entries (branch source/destination pairs) from the CFA monitor over a valid/ready handshake.
- Writes each entry as two words through the memory's dual-word write port and tracks the log fill pointer.
- Raises a report request to software when the log is full or a flush is requested, then zero-clears the used region after software acknowledges.
- Sits between the CFA monitor and cflogmem; it drives the memory's write address, data, write enable and chip enable.

Parameters:
- LOG_WORDS, 512, log capacity in 16-bit words (memory bytes / 2); must be even.
- ADDR_MSB, 9, MSB of the word address; ADDR_MSB+1 bits must hold LOG_WORDS.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  logging enable from the CFA config register
- entry_valid  in  1  monitor presents an entry
- entry_src  in  16  branch source address
- entry_dst  in  16  branch destination address
- entry_ready  out  1  controller accepts the entry this cycle
- sw_flush_req  in  1  software/early-report request (single-cycle pulse)
- sw_ack  in  1  software finished reading the log (single-cycle pulse)
- sw_rd_en  in  1  software read access to the log
- ram_wen  out  2  write enable to memory (2'b11 = write both words)
- write_addr  out  ADDR_MSB+1  word address of the first word of the pair
- ram_din1  out  16  first word (src)
- ram_din2  out  16  second word (dst)
- ram_cen  out  1  memory chip enable, active low, gates software reads
- log_ptr  out  ADDR_MSB+1  words written since the last clear
- irq_report  out  1  report request to software, level
- ctrl_state  out  2  current FSM state, for debug/status

Behaviour:
- States: IDLE=0, LOG=1, REPORT=2, CLEAR=3.
- Reset values: state IDLE, log_ptr 0, clr_ptr 0, entry_ready 0, ram_wen 0, irq_report 0, ram_cen 1, write_addr 0, ram_din1/2 0.
- Reset mid-operation aborts any write or clear, with no memory write in the reset cycle.
- IDLE -> LOG when enable=1. log_ptr is retained across IDLE.
- LOG: entry_ready = (log_ptr <= LOG_WORDS-2).
  - An entry is accepted when entry_valid & entry_ready.
  - In the same cycle: ram_wen=2'b11, write_addr=log_ptr, ram_din1=entry_src, ram_din2=entry_dst. Write outputs are combinational from the handshake, so the write commits at that clock edge.
  - log_ptr += 2 at that edge.
- LOG -> REPORT when:
  - the accept makes log_ptr reach LOG_WORDS (full), or
  - sw_flush_req=1 and log_ptr != 0, or the flush coincides with an accept.
  - An accept and a flush in the same cycle: the entry is written first, then REPORT.
  - A flush with log_ptr=0 and no accept is ignored.
- LOG -> IDLE when enable=0 and no accept this cycle. An accept in the cycle enable falls is still written.
- REPORT:
  - irq_report=1, entry_ready=0, no writes.
  - ram_cen = ~sw_rd_en. Outside REPORT, ram_cen=1.
  - sw_ack -> CLEAR with clr_ptr=0.
- CLEAR:
  - One pair cleared per cycle: ram_wen=2'b11, write_addr=clr_ptr, din1=din2=0, clr_ptr += 2.
  - When clr_ptr+2 >= log_ptr, log_ptr<=0 and go to LOG if enable, else IDLE.
  - irq_report=0 and entry_ready=0 throughout.
- sw_ack outside REPORT is ignored. sw_flush_req outside LOG is ignored.
- Counter widths: log_ptr and clr_ptr are ADDR_MSB+1 bits and never exceed LOG_WORDS; no wrap-around is ever performed.
- ram_wen is never nonzero with write_addr > LOG_WORDS-2.
- Latency: accept-to-memory is 0 cycles (same edge). Full-to-irq_report is 1 cycle. Clear time is log_ptr/2 cycles.

Decomposition:
- Shared package cflog_pkg holds:
  - state encodings IDLE/LOG/REPORT/CLEAR
  - WEN_BOTH=2'b11 and WEN_NONE=2'b00
  - defaults for LOG_WORDS/ADDR_MSB, so the controller and cflogmem stay consistent
- No sub-module; a single FSM plus two pointers. The write-port mux (log write vs. clear write) stays inline.

Test Plan:
- Reset, enable=1, send (src 16'hE0A2, dst 16'hE100) -> same-cycle ram_wen=2'b11, write_addr=0, din1=E0A2, din2=E100; then log_ptr=2 and cflogmem words 0/1 hold the pair.
- Send 256 back-to-back entries with LOG_WORDS=512 -> last write at address 510, log_ptr=512, next cycle irq_report=1, entry_ready=0; a 257th entry_valid stalls.
- After 3 entries, pulse sw_flush_req in the same cycle as a 4th accept -> 4th entry written at address 6, log_ptr=8, REPORT entered.
- In REPORT, sw_rd_en=1 -> ram_cen=0. Pulse sw_ack -> exactly 4 CLEAR cycles writing zeros at 0, 2, 4, 6, then log_ptr=0, state LOG, entry_ready=1.
- sw_flush_req with log_ptr=0 and sw_ack while in LOG -> no state change, no writes.
- Assert reset during CLEAR at clr_ptr=4 -> next cycle state IDLE, log_ptr=0, ram_wen=0, irq_report=0, ram_cen=1.
